// File: rtl/alu_issue_pkg.sv
// Shared ISA constants for the issue stage, ALU and decoder: opcodes, ALU ops,
// the bubble encoding and the carry-consumer set.
package alu_issue_pkg;

  typedef enum logic [2:0] {
    OP_ALU  = 3'b000,
    OP_ADDI = 3'b001,
    OP_ILL  = 3'b010,
    OP_LUI  = 3'b011,
    OP_SW   = 3'b100,
    OP_LW   = 3'b101,
    OP_BR   = 3'b110,
    OP_JALR = 3'b111
  } op_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDC = 4'b0010;
  localparam logic [3:0] ALU_SUBC = 4'b0100;
  localparam logic [3:0] ALU_RSBC = 4'b1110;
  localparam logic [3:0] ALU_CMPC = 4'b1111;

  localparam op_e BUBBLE_OP = OP_BR;

  typedef struct packed {
    op_e         op;
    logic [3:0]  alu_op;
    logic [15:0] s_1;
    logic [15:0] s_2;
    logic        valid;
    logic [2:0]  dest;
    logic        wr_en;
    logic        is_load;
  } issue_t;

  localparam issue_t BUBBLE = '{
    op: BUBBLE_OP, alu_op: ALU_ADD, s_1: '0, s_2: '0,
    valid: 1'b0, dest: '0, wr_en: 1'b0, is_load: 1'b0
  };

  function automatic logic is_carry_consumer(input logic [3:0] a);
    return (a == ALU_ADDC) || (a == ALU_SUBC) || (a == ALU_RSBC) || (a == ALU_CMPC);
  endfunction

  function automatic logic [15:0] sext7(input logic [6:0] imm);
    return {{9{imm[6]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Two-entry skid FIFO holding instruction word and pc ahead of issue.
module issue_skid #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] push_instr,
  input  logic [15:0] push_pc,
  output logic [15:0] head_instr,
  output logic [15:0] head_pc,
  output logic [1:0]  count
);

  logic [15:0] mem_instr [DEPTH];
  logic [15:0] mem_pc    [DEPTH];
  logic        wr_ptr;
  logic        rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= push_instr;
        mem_pc[wr_ptr]    <= push_pc;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_instr = mem_instr[rd_ptr];
  assign head_pc    = mem_pc[rd_ptr];

endmodule

// File: rtl/alu_issue.sv
// Issue stage: buffers instructions, reads/forwards operands, resolves
// load-use hazards and presents registered operands to the ALU.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  input  logic [15:0] pc,
  input  logic        stall,
  output logic [2:0]  rf_ra,
  output logic [2:0]  rf_rb,
  input  logic [15:0] rf_da,
  input  logic [15:0] rf_db,
  input  logic [15:0] alu_result,
  output logic [2:0]  op,
  output logic [3:0]  alu_op,
  output logic [15:0] s_1,
  output logic [15:0] s_2,
  output logic        out_valid,
  output logic [2:0]  dest,
  output logic        wr_en,
  output logic        is_load,
  output logic [1:0]  err
);

  logic [1:0]  count;
  logic [15:0] head_instr, head_pc;
  logic        push, pop, issue, load_use, fwd_ok, use_a, use_b;
  logic [15:0] opnd_a, opnd_b;
  op_e         h_op;
  logic [2:0]  h_ra, h_rb, h_rc;
  issue_t      out_q, nxt;
  logic [1:0]  err_q;

  assign in_ready = (count < 2'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = issue;

  issue_skid #(.DEPTH(DEPTH)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .push_instr (instr),
    .push_pc    (pc),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (count)
  );

  assign h_op = op_e'(head_instr[15:13]);
  assign h_ra = head_instr[12:10];
  assign h_rb = head_instr[9:7];
  assign h_rc = head_instr[2:0];

  // Port a carries the first source: rA for branches, rB otherwise.
  assign rf_ra = (h_op == OP_BR) ? h_ra : h_rb;
  assign rf_rb = (h_op == OP_BR) ? h_rb : h_rc;
  assign use_a = (h_op != OP_ILL) && (h_op != OP_LUI);
  assign use_b = (h_op == OP_ALU) || (h_op == OP_BR);

  assign fwd_ok = out_q.valid && out_q.wr_en && !out_q.is_load && (out_q.dest != '0);
  assign opnd_a = (rf_ra == '0) ? '0 : (fwd_ok && out_q.dest == rf_ra) ? alu_result : rf_da;
  assign opnd_b = (rf_rb == '0) ? '0 : (fwd_ok && out_q.dest == rf_rb) ? alu_result : rf_db;

  // The lw on the outputs is replaced by a bubble next edge, so the block
  // lasts exactly one edge without separate hazard state.
  assign load_use = out_q.valid && out_q.is_load && (out_q.dest != '0) &&
                    ((use_a && rf_ra == out_q.dest) || (use_b && rf_rb == out_q.dest));
  assign issue    = !rst && !stall && (count != '0) && !load_use;

  always_comb begin
    nxt       = BUBBLE;
    nxt.valid = 1'b1;
    nxt.op    = h_op;
    unique case (h_op)
      OP_ALU: begin
        nxt.s_1 = opnd_a;  nxt.s_2 = opnd_b;  nxt.alu_op = head_instr[6:3];
        nxt.dest = h_ra;   nxt.wr_en = 1'b1;
      end
      OP_ADDI: begin
        nxt.s_1 = opnd_a;  nxt.s_2 = sext7(head_instr[6:0]);
        nxt.dest = h_ra;   nxt.wr_en = 1'b1;
      end
      OP_ILL:  nxt.op = BUBBLE_OP;
      OP_LUI: begin
        nxt.s_1 = {head_instr[9:0], 6'b0};
        nxt.dest = h_ra;   nxt.wr_en = 1'b1;
      end
      OP_SW: begin
        nxt.s_1 = opnd_a;  nxt.s_2 = sext7(head_instr[6:0]);
      end
      OP_LW: begin
        nxt.s_1 = opnd_a;  nxt.s_2 = sext7(head_instr[6:0]);
        nxt.dest = h_ra;   nxt.wr_en = 1'b1;  nxt.is_load = 1'b1;
      end
      OP_BR: begin
        nxt.s_1 = opnd_a;  nxt.s_2 = opnd_b;
      end
      OP_JALR: begin
        nxt.s_1 = head_pc + 16'd1;  nxt.s_2 = opnd_a;
        nxt.dest = h_ra;   nxt.wr_en = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= BUBBLE;
      err_q <= '0;
    end else if (!stall) begin
      if (issue) begin
        out_q    <= nxt;
        err_q[0] <= err_q[0] | ((h_op == OP_ALU) && is_carry_consumer(head_instr[6:3]) && !out_q.valid);
        err_q[1] <= err_q[1] | (h_op == OP_ILL);
      end else begin
        out_q <= BUBBLE;
      end
    end
  end

  assign op        = out_q.op;
  assign alu_op    = out_q.alu_op;
  assign s_1       = out_q.s_1;
  assign s_2       = out_q.s_2;
  assign out_valid = out_q.valid;
  assign dest      = out_q.dest;
  assign wr_en     = out_q.wr_en;
  assign is_load   = out_q.is_load;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a queue-based reference model predicts the
// output state after every edge; a monitor pops and compares after each edge.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] instr = '0;
  logic [15:0] pc = '0;
  logic        stall = 1'b0;
  logic [2:0]  rf_ra, rf_rb;
  logic [15:0] rf_da, rf_db;
  logic [15:0] alu_result = '0;
  logic [2:0]  op;
  logic [3:0]  alu_op;
  logic [15:0] s_1, s_2;
  logic        out_valid, wr_en, is_load;
  logic [2:0]  dest;
  logic [1:0]  err;

  always #5 clk = ~clk;

  alu_issue #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .stall(stall), .rf_ra(rf_ra), .rf_rb(rf_rb),
    .rf_da(rf_da), .rf_db(rf_db), .alu_result(alu_result), .op(op),
    .alu_op(alu_op), .s_1(s_1), .s_2(s_2), .out_valid(out_valid),
    .dest(dest), .wr_en(wr_en), .is_load(is_load), .err(err)
  );

  logic [15:0] regs [8];
  assign rf_da = regs[rf_ra];
  assign rf_db = regs[rf_rb];

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  alu_op;
    logic [15:0] s1, s2;
    logic        v, wr, ld;
    logic [2:0]  dest;
    logic [1:0]  err;
    logic        rdy;
  } exp_t;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] pc;
  } ent_t;

  exp_t sb[$];
  ent_t mq[$];
  exp_t cur;
  logic [1:0] merr;
  int checks = 0;
  int failures = 0;

  function automatic exp_t bubble();
    exp_t b;
    b.op = 3'b110; b.alu_op = 4'b0000; b.s1 = '0; b.s2 = '0;
    b.v = 1'b0; b.wr = 1'b0; b.ld = 1'b0; b.dest = '0; b.err = '0; b.rdy = 1'b1;
    return b;
  endfunction

  function automatic logic [15:0] rd(input logic [2:0] r, input logic [15:0] alu);
    if (r == 3'd0) return 16'h0000;
    if (cur.v && cur.wr && !cur.ld && cur.dest != 3'd0 && cur.dest == r) return alu;
    return regs[r];
  endfunction

  function automatic logic hazard(input logic [15:0] ins);
    logic [2:0] o, ra, rb, rc, d;
    o = ins[15:13]; ra = ins[12:10]; rb = ins[9:7]; rc = ins[2:0]; d = cur.dest;
    if (!(cur.v && cur.ld && d != 3'd0)) return 1'b0;
    case (o)
      3'd0:                return (rb == d) || (rc == d);
      3'd1, 3'd4, 3'd5, 3'd7: return rb == d;
      3'd6:                return (ra == d) || (rb == d);
      default:             return 1'b0;
    endcase
  endfunction

  function automatic exp_t execute(input ent_t e, input logic [15:0] alu);
    exp_t n;
    logic [2:0]  o, ra, rb, rc;
    logic [15:0] simm;
    n = bubble();
    o = e.ins[15:13]; ra = e.ins[12:10]; rb = e.ins[9:7]; rc = e.ins[2:0];
    simm = {{9{e.ins[6]}}, e.ins[6:0]};
    n.v = 1'b1;
    n.op = o;
    case (o)
      3'd0: begin n.s1 = rd(rb, alu); n.s2 = rd(rc, alu); n.alu_op = e.ins[6:3]; n.dest = ra; n.wr = 1; end
      3'd1: begin n.s1 = rd(rb, alu); n.s2 = simm; n.dest = ra; n.wr = 1; end
      3'd2: n.op = 3'b110;
      3'd3: begin n.s1 = {e.ins[9:0], 6'b000000}; n.dest = ra; n.wr = 1; end
      3'd4: begin n.s1 = rd(rb, alu); n.s2 = simm; end
      3'd5: begin n.s1 = rd(rb, alu); n.s2 = simm; n.dest = ra; n.wr = 1; n.ld = 1; end
      3'd6: begin n.s1 = rd(ra, alu); n.s2 = rd(rb, alu); end
      default: begin n.s1 = e.pc + 16'd1; n.s2 = rd(rb, alu); n.dest = ra; n.wr = 1; end
    endcase
    return n;
  endfunction

  // One clock of stimulus; the model predicts the state after the coming edge.
  task automatic step(input logic r, input logic iv, input logic [15:0] ins,
                      input logic [15:0] p, input logic st);
    logic        acc;
    logic [15:0] alu;
    ent_t        ent;
    exp_t        e;
    logic [3:0]  a;
    @(negedge clk);
    rst = r; in_valid = iv; instr = ins; pc = p; stall = st;
    alu = cur.s1 + cur.s2;
    alu_result = alu;
    if (r) begin
      mq.delete();
      cur  = bubble();
      merr = '0;
    end else begin
      acc = iv && (mq.size() < 2);
      if (!st) begin
        if (mq.size() > 0 && !hazard(mq[0].ins)) begin
          a = mq[0].ins[6:3];
          if (mq[0].ins[15:13] == 3'd0 && (a == 4'h2 || a == 4'h4 || a == 4'hE || a == 4'hF) && !cur.v)
            merr[0] = 1'b1;
          if (mq[0].ins[15:13] == 3'd2) merr[1] = 1'b1;
          cur = execute(mq[0], alu);
          void'(mq.pop_front());
        end else begin
          cur = bubble();
        end
      end
      if (acc) begin
        ent.ins = ins; ent.pc = p;
        mq.push_back(ent);
      end
    end
    e = cur;
    e.err = merr;
    e.rdy = (mq.size() < 2);
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("op",        {13'd0, op},        {13'd0, e.op});
        chk("alu_op",    {12'd0, alu_op},    {12'd0, e.alu_op});
        chk("s_1",       s_1,                e.s1);
        chk("s_2",       s_2,                e.s2);
        chk("out_valid", {15'd0, out_valid}, {15'd0, e.v});
        chk("dest",      {13'd0, dest},      {13'd0, e.dest});
        chk("wr_en",     {15'd0, wr_en},     {15'd0, e.wr});
        chk("is_load",   {15'd0, is_load},   {15'd0, e.ld});
        chk("err",       {14'd0, err},       {14'd0, e.err});
        chk("in_ready",  {15'd0, in_ready},  {15'd0, e.rdy});
      end
    end
  end

  function automatic logic [15:0] enc(input logic [2:0] o, input logic [2:0] ra,
                                      input logic [2:0] rb, input logic [6:0] lo);
    return {o, ra, rb, lo};
  endfunction

  initial begin : stim
    logic [15:0] ri;
    cur  = bubble();
    merr = '0;
    regs[0] = 16'hBEEF;
    for (int unsigned i = 1; i < 8; i++) regs[i] = 16'($urandom);

    step(1, 0, '0, '0, 0);
    step(1, 0, '0, '0, 0);
    // forwarding: addi r1,r0,5 ; add r2,r1,r1
    step(0, 1, enc(3'd1, 3'd1, 3'd0, 7'd5), 16'h0010, 0);
    step(0, 1, enc(3'd0, 3'd2, 3'd1, {4'b0000, 3'd1}), 16'h0011, 0);
    step(0, 0, '0, '0, 0);
    step(0, 0, '0, '0, 0);
    // load-use: lw r3 ; add r4,r3,r0
    step(0, 1, enc(3'd5, 3'd3, 3'd1, 7'd2), 16'h0020, 0);
    step(0, 1, enc(3'd0, 3'd4, 3'd3, {4'b0000, 3'd0}), 16'h0021, 0);
    repeat (3) step(0, 0, '0, '0, 0);
    // addc after a bubble sets the sticky carry hazard
    step(0, 1, enc(3'd0, 3'd5, 3'd1, {4'b0010, 3'd2}), 16'h0030, 0);
    repeat (3) step(0, 0, '0, '0, 0);
    // fill under stall, then drain in order
    step(0, 1, enc(3'd1, 3'd6, 3'd2, 7'h7F), 16'h0040, 1);
    step(0, 1, enc(3'd3, 3'd7, 3'd0, 7'h55), 16'h0041, 1);
    step(0, 1, enc(3'd6, 3'd1, 3'd2, 7'h00), 16'h0042, 1);
    step(0, 0, '0, '0, 1);
    repeat (3) step(0, 0, '0, '0, 0);
    // jalr pc wrap, illegal op
    step(0, 1, enc(3'd7, 3'd6, 3'd2, 7'd0), 16'hFFFF, 0);
    step(0, 1, enc(3'd2, 3'd3, 3'd3, 7'h33), 16'h0050, 0);
    repeat (2) step(0, 0, '0, '0, 0);
    // reset mid-stream while stalled
    step(0, 1, enc(3'd1, 3'd2, 3'd3, 7'd9), 16'h0060, 1);
    step(0, 1, enc(3'd0, 3'd3, 3'd2, {4'b0100, 3'd1}), 16'h0061, 1);
    step(1, 1, enc(3'd1, 3'd4, 3'd2, 7'd1), 16'h0062, 1);
    repeat (2) step(0, 0, '0, '0, 0);

    // random traffic with small register range to provoke hazards
    for (int unsigned n = 0; n < 400; n++) begin
      ri = enc(3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
               {4'($urandom), 3'($urandom_range(0, 3))});
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), ri,
           16'($urandom), ($urandom_range(0, 3) == 0));
    end

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, skid FIFO entry count; only 2 is supported.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, instruction offered.
REQ-005 SHALL have port in_ready, output, 1, block accepts the instruction.
REQ-006 SHALL have port instr, input, 16, instruction word: op[15:13], rA[12:10], rB[9:7], alu_op[6:3], rC[2:0], imm7[6:0], imm10[9:0].
REQ-007 SHALL have port pc, input, 16, address of instr.
REQ-008 SHALL have port stall, input, 1, downstream hold request.
REQ-009 SHALL have ports rf_ra and rf_rb, output, 3 each, register-file read addresses (combinational from the FIFO head).
REQ-010 SHALL have ports rf_da and rf_db, input, 16 each, register-file read data (combinational).
REQ-011 SHALL have port alu_result, input, 16, ALU result of the instruction currently on the outputs.
REQ-012 SHALL have registered outputs op (3), alu_op (4), s_1 (16), s_2 (16), out_valid (1), dest (3), wr_en (1), is_load (1), err (2; sticky, bit0 carry hazard, bit1 illegal op).

Function
REQ-013 SHALL accept instr/pc into the FIFO on an edge with in_valid && in_ready; in_ready = (count < 2); no same-cycle pass-through when full.
REQ-014 SHALL issue the FIFO head (pop, load the output registers) on an edge with count > 0, stall = 0, and no load-use block; an instruction accepted at edge E issues at edge E+1 at the earliest; sustained throughput 1/cycle.
REQ-015 SHALL, when stall = 1, hold every output register, FIFO pop, and load-use state unchanged; FIFO push is still permitted.
REQ-016 SHALL, on a non-stalled edge with no issue, load the bubble: op=110, alu_op=0000, s_1=s_2=0, out_valid=0, wr_en=0, dest=0, is_load=0.
REQ-017 SHALL map op 000: s_1=R[rB], s_2=R[rC], alu_op=instr[6:3], dest=rA, wr_en=1.
REQ-018 SHALL map op 001 (addi): s_1=R[rB], s_2=sign-extend(imm7), dest=rA, wr_en=1.
REQ-019 SHALL map op 011 (lui): s_1={imm10,6'b0}, s_2=0, dest=rA, wr_en=1.
REQ-020 SHALL map op 100 (sw): s_1=R[rB], s_2=sext(imm7), wr_en=0.
REQ-021 SHALL map op 101 (lw): the sw operands, dest=rA, wr_en=1, is_load=1.
REQ-022 SHALL map op 110 (branch): s_1=R[rA], s_2=R[rB], wr_en=0.
REQ-023 SHALL map op 111 (jalr): s_1=pc+1 (mod 2^16), s_2=R[rB], dest=rA, wr_en=1.
REQ-024 SHALL issue op 010 as a bubble with out_valid=1, wr_en=0, and set err[1].
REQ-025 SHALL read R[0] as 0 regardless of rf data or forwarding.
REQ-026 SHALL forward alu_result in place of rf data for a source register equal to the current output dest when out_valid && wr_en && !is_load && dest != 0.
REQ-027 SHALL hold issue for exactly one edge (a bubble) when the head reads the dest of an issued lw with dest != 0; after that edge, the operand comes from rf data.
REQ-028 SHALL set err[0] when issuing a carry consumer (op 000, alu_op 0010/0100/1110/1111) while the current outputs hold a bubble (out_valid=0), since flags are then stale; the instruction still issues.
REQ-029 SHALL clear err only on reset.

Reset
REQ-030 SHALL, on rst=1 at an edge, empty the FIFO, load the bubble into the outputs, clear err and load-use state; rst overrides push, pop, and stall.
REQ-031 SHALL drive in_ready=1 in the first cycle after reset release; an instruction in flight when reset is asserted is discarded.

Structure
REQ-032 SHALL take op encodings, alu_op encodings, bubble values, and the carry-consumer set from a shared ISA constants package also used by the ALU and decoder.
REQ-033 SHALL implement the 2-entry FIFO as sub-module issue_skid (push/pop/count, data+pc).

Verification
REQ-034 Reset, then addi r1,r0,5 then add r2,r1,r1 back-to-back -> second issue has s_1=s_2=5 via forwarding, out_valid=1 both cycles.
REQ-035 lw r3 then add r4,r3,r0 -> exactly one bubble (out_valid=0) between them; err=00.
REQ-036 Bubble, then addc -> err[0]=1 and remains 1 until rst.
REQ-037 Fill FIFO with stall=1 -> in_ready=0 at count 2, outputs frozen; release stall -> two consecutive issues in order.
REQ-038 jalr at pc=16'hFFFF -> s_1=0; op 010 -> err[1]=1, wr_en=0.
REQ-039 rst asserted mid-stream with stall=1 -> next cycle bubble outputs, in_ready=1, err=00.
